serial_comparator_ctrl: RTL
===========================

SERIAL_COMPARATOR_CTRL -- requirements
Module: serial_comparator_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 1, bits compared per cycle; WIDTH % DIGIT == 0 required.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; operands sampled when accepted.
REQ-006 SHALL have port a_in  input  WIDTH  operand A.
REQ-007 SHALL have port b_in  input  WIDTH  operand B.
REQ-008 SHALL have port busy  output  1  high while a comparison is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have ports less_than, equal_to, greater_than  output  1 each  result flags, one-hot when valid.

Function
REQ-011 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-012 SHALL accept start only in IDLE or DONE; on acceptance, latch a_in/b_in, clear all flags, enter SCAN.
REQ-013 SHALL ignore start while in SCAN; latched operands unchanged.
REQ-014 SHALL compare one DIGIT-wide slice per SCAN cycle, MSB slice first; N = WIDTH/DIGIT slices.
REQ-015 SHALL leave SCAN on the first unequal slice (early exit) and set less_than or greater_than from that slice.
REQ-016 SHALL set equal_to when all N slices match, after exactly N SCAN cycles.
REQ-017 SHALL assert busy in SCAN only; SHALL assert done for exactly the DONE cycle.
REQ-018 Latency: start accepted at edge 0; k SCAN cycles, k = 1-based index of first differing slice (N if equal); done high during cycle k+1.
REQ-019 SHALL hold result flags after DONE until the next accepted start or reset.
REQ-020 Start high in the DONE cycle SHALL be accepted (back-to-back); the next SCAN starts the following cycle.
REQ-021 Slice counter SHALL be ceil(log2(N+1)) bits wide; no wrap-around in a legal sequence.

Reset
REQ-022 On reset high at a rising edge: state IDLE, busy=0, done=0, all flags=0, counter=0.
REQ-023 Reset SHALL take priority over start and abort any SCAN in progress with no done pulse.

Configuration
REQ-024 Macro SERIAL_COMPARATOR_SIGNED_EN defined: extra input signed_mode (1 bit), sampled with operands; when 1, operands are two's complement (MSB of each operand inverted before comparison).
REQ-025 Macro not defined: no signed_mode port; unsigned comparison only.

Structure
REQ-026 Package serial_comparator_pkg SHALL hold the FSM state enum and the one-hot result encoding constants.
REQ-027 Sub-module digit_compare (combinational, DIGIT-wide, outputs lt/gt) SHALL be instantiated once for the current slice.

Verification (WIDTH=8, DIGIT=2 unless stated)
REQ-028 a=0xA5, b=0xA7, start -> busy for 4 cycles, done in cycle 5, less_than=1, others 0.
REQ-029 a=0x80, b=0x7F -> greater_than after 1 SCAN cycle; with SERIAL_COMPARATOR_SIGNED_EN and signed_mode=1 -> less_than.
REQ-030 a=0x3C, b=0x3C -> 4 SCAN cycles, equal_to=1; flags held until next start.
REQ-031 start pulsed during SCAN with new operands -> ignored, result matches original operands; reset mid-SCAN -> next cycle IDLE, all outputs 0, no done.
REQ-032 start held high in DONE cycle with a=0x01, b=0x02 -> accepted; flags cleared, new result less_than after 4 SCAN cycles.
REQ-033 WIDTH=4, DIGIT=1, a=0xA, b=0xB -> less_than after 4 SCAN cycles, done in cycle 5.

Source files
------------

// File: rtl/serial_comparator_pkg.sv
// Shared types for the serial comparator: FSM states and one-hot result codes.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Result flags are packed as {less_than, equal_to, greater_than}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

endpackage

// File: rtl/serial_comparator_ctrl_digit_compare.sv
// Combinational magnitude compare of one DIGIT-wide slice.
module digit_compare #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/serial_comparator_ctrl.sv
// Serial MSB-first magnitude comparator with early exit on the first unequal slice.
// Optional signed comparison enabled by defining SERIAL_COMPARATOR_SIGNED_EN.
module serial_comparator_ctrl
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             less_than,
  output logic             equal_to,
  output logic             greater_than
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       res_q, res_d;

  logic [WIDTH-1:0] opA, opB;
  logic             sliceLt, sliceGt;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  always_comb begin
    opA = a_in;
    opB = b_in;
`ifdef SERIAL_COMPARATOR_SIGNED_EN
    if (signed_mode) begin
      opA[WIDTH-1] = ~a_in[WIDTH-1];
      opB[WIDTH-1] = ~b_in[WIDTH-1];
    end
`endif
  end

  // Operands shift left each SCAN cycle, so the current slice is always the top DIGIT bits.
  digit_compare #(
    .DIGIT(DIGIT)
  ) u_digit_compare (
    .a  (a_q[WIDTH-1 -: DIGIT]),
    .b  (b_q[WIDTH-1 -: DIGIT]),
    .lt (sliceLt),
    .gt (sliceGt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = opA;
          b_d     = opB;
          cnt_d   = '0;
          res_d   = RES_NONE;
          state_d = ST_SCAN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        cnt_d = cnt_q + CW'(1);
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        if (sliceLt) begin
          res_d   = RES_LT;
          state_d = ST_DONE;
        end else if (sliceGt) begin
          res_d   = RES_GT;
          state_d = ST_DONE;
        end else if (cnt_q == LAST_SLICE) begin
          res_d   = RES_EQ;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q == ST_SCAN);
  assign done = (state_q == ST_DONE);
  assign {less_than, equal_to, greater_than} = res_q;

endmodule
